// File: rtl/retire_trace_fifo_pkg.sv
// -----------------------------------------------------------------------------
// retire_trace_fifo_pkg
// Shared debug package for the retirement trace path.
//   TRACE_SEQ_W  : width of the sequence stamp carried in each record
//   OP_*         : RV32 major opcode values (instr[6:0]) for decoding trace
//   trace_rec_t  : one retired-instruction record, seq in the MSBs
//   TRACE_W      : packed record width (158 bits with a 16-bit stamp)
// Everything here exists only for trace/debug builds. Defining
// NO_DEBUG_TRACE removes it so that production netlists carry none of it.
// -----------------------------------------------------------------------------
package retire_trace_fifo_pkg;
`ifndef NO_DEBUG_TRACE
   localparam int TRACE_SEQ_W = 16;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [31:0]            pc;
      logic [6:0]             op;
      logic [4:0]             rd;
      logic                   regwrite;
      logic                   dmem_we;
      logic [31:0]            result;
      logic [31:0]            dmem_addr;
      logic [31:0]            dmem_wd;
   } trace_rec_t;

   localparam int TRACE_W = $bits(trace_rec_t);
`endif
endpackage

// File: rtl/trace_fifo_mem.sv
// -----------------------------------------------------------------------------
// trace_fifo_mem
// DEPTH x W storage for the trace FIFO: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset; the FIFO
// pointers decide which words are meaningful.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module trace_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 158
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// retire_trace_fifo
// Captures one record per retired instruction into a small FIFO for a trace
// consumer. Every capture attempt gets a sequence stamp, so a consumer can
// spot gaps caused by drops. When full and not draining, new records are
// dropped and counted (saturating) with a sticky overflow flag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   trace_en             : capture enable (0 ignores ret_valid)
//   ret_*                : retirement information for this cycle
//   out_valid/out_ready  : head-entry handshake to the consumer
//   out_rec              : head record (oldest entry)
//   count                : occupancy 0..DEPTH
//   overflow, drop_cnt   : drop reporting; clr_drop clears both
//
// Handshake: out_valid is high exactly when count != 0 and does not depend
// on out_ready. The head entry is consumed on a rising edge where
// out_valid && out_ready. A record pushed at edge N first appears on out_rec
// after edge N (no fall-through), so an empty FIFO never pops.
// -----------------------------------------------------------------------------
module retire_trace_fifo
   import retire_trace_fifo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int SEQ_W  = 16,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     trace_en,
   input  logic                     ret_valid,
   input  logic [31:0]              ret_pc,
   input  logic [6:0]               ret_op,
   input  logic [4:0]               ret_rd,
   input  logic [31:0]              ret_result,
   input  logic                     ret_regwrite,
   input  logic                     ret_dmem_we,
   input  logic [31:0]              ret_dmem_addr,
   input  logic [31:0]              ret_dmem_wd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output trace_rec_t               out_rec,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt,
   input  logic                     clr_drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("retire_trace_fifo: DEPTH must be a power of two >= 2");
   end

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              overflow_q, overflow_d;

   logic       push, pop, full, accept, drop;
   trace_rec_t wr_rec;

   assign push   = trace_en && ret_valid;
   assign full   = (count_q == FULL_CNT);
   assign pop    = out_valid && out_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   always_comb begin
      wr_rec           = '0;
      wr_rec.seq       = TRACE_SEQ_W'(seq_q);
      wr_rec.pc        = ret_pc;
      wr_rec.op        = ret_op;
      wr_rec.rd        = ret_rd;
      wr_rec.regwrite  = ret_regwrite;
      wr_rec.dmem_we   = ret_dmem_we;
      wr_rec.result    = ret_result;
      wr_rec.dmem_addr = ret_dmem_addr;
      wr_rec.dmem_wd   = ret_dmem_wd;
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      seq_d      = seq_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;

      if (accept) wptr_d = wptr_q + 1'b1;
      if (pop)    rptr_d = rptr_q + 1'b1;

      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // The stamp advances on every capture attempt, dropped or not.
      if (push) seq_d = seq_q + 1'b1;

      // Clear takes priority over a coincident drop.
      if (clr_drop) begin
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         seq_q      <= seq_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   trace_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (TRACE_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (accept),
      .waddr_i (wptr_q),
      .wdata_i (wr_rec),
      .raddr_i (rptr_q),
      .rdata_o (out_rec)
   );

   assign out_valid = (count_q != '0);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_fifo
// Directed bench for retire_trace_fifo at DEPTH=8, SEQ_W=16, DROP_W=16.
// Each record's non-seq fields are derived from its PC by mk_rec so an
// expected record only needs (seq, pc).
// -----------------------------------------------------------------------------
module tb_retire_trace_fifo;
   import retire_trace_fifo_pkg::*;

   localparam int DEPTH  = 8;
   localparam int SEQ_W  = 16;
   localparam int DROP_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              trace_en = 1'b0;
   logic              ret_valid = 1'b0;
   logic [31:0]       ret_pc = '0;
   logic [6:0]        ret_op = '0;
   logic [4:0]        ret_rd = '0;
   logic [31:0]       ret_result = '0;
   logic              ret_regwrite = 1'b0;
   logic              ret_dmem_we = 1'b0;
   logic [31:0]       ret_dmem_addr = '0;
   logic [31:0]       ret_dmem_wd = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   trace_rec_t        out_rec;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;
   logic              clr_drop = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   retire_trace_fifo #(
      .DEPTH  (DEPTH),
      .SEQ_W  (SEQ_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .trace_en      (trace_en),
      .ret_valid     (ret_valid),
      .ret_pc        (ret_pc),
      .ret_op        (ret_op),
      .ret_rd        (ret_rd),
      .ret_result    (ret_result),
      .ret_regwrite  (ret_regwrite),
      .ret_dmem_we   (ret_dmem_we),
      .ret_dmem_addr (ret_dmem_addr),
      .ret_dmem_wd   (ret_dmem_wd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rec       (out_rec),
      .count         (count),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt),
      .clr_drop      (clr_drop)
   );

   task automatic check_val(input string tag, input logic [TRACE_W-1:0] got,
                            input logic [TRACE_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic trace_rec_t mk_rec(input logic [15:0] s, input logic [31:0] pc);
      trace_rec_t r;
      r.seq       = s;
      r.pc        = pc;
      r.op        = pc[2] ? OP_STORE : OP_OP;
      r.rd        = pc[6:2];
      r.regwrite  = ~pc[2];
      r.dmem_we   = pc[2];
      r.result    = pc ^ 32'hdead_beef;
      r.dmem_addr = pc + 32'h1000;
      r.dmem_wd   = ~pc;
      return r;
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // in that same window, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic en, input logic push, input logic [31:0] pc,
                         input logic rdy, input logic clr);
      trace_rec_t r;
      r             = mk_rec(16'h0, pc);
      trace_en      = en;
      ret_valid     = push;
      ret_pc        = r.pc;
      ret_op        = r.op;
      ret_rd        = r.rd;
      ret_result    = r.result;
      ret_regwrite  = r.regwrite;
      ret_dmem_we   = r.dmem_we;
      ret_dmem_addr = r.dmem_addr;
      ret_dmem_wd   = r.dmem_wd;
      out_ready     = rdy;
      clr_drop      = clr;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int          pop_idx;
      int          stream_errs;
      logic [15:0] w0, w1;

      // ---- reset values ----
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #12;
      check_val("rst_count", count, 0);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_drop", drop_cnt, 0);
      tick();
      rst_n = 1'b1;

      // ---- trace_en=0 ignores ret_valid ----
      set_in(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
      tick();
      check_val("en0_count", count, 0);

      // ---- three pushes, then in-order drain ----
      set_in(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      check_val("no_fallthru", out_valid, 0);
      tick();
      check_val("valid_after_push", out_valid, 1);
      set_in(1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 32'h8, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check_val("three_count", count, 3);
      tick();
      check_val("hold_count", count, 3);
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("drain3_rec%0d", i), out_rec, mk_rec(16'(i), 32'(i * 4)));
         tick();
      end
      check_val("drain3_valid", out_valid, 0);
      check_val("drain3_count", count, 0);

      // ---- overflow: 10 pushes into 8 entries ----
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check_val("ovf_count", count, 8);
      check_val("ovf_drop", drop_cnt, 2);
      check_val("ovf_flag", overflow, 1);
      check_val("ovf_head", out_rec, mk_rec(16'd0, 32'h100));

      // ---- full with push and pop together: push carries seq 10 ----
      set_in(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check_val("fullpp_count", count, 8);
      check_val("fullpp_drop", drop_cnt, 2);
      for (int i = 1; i < 8; i++) begin
         check_val($sformatf("ovf_drain_rec%0d", i), out_rec,
                   mk_rec(16'(i), 32'h100 + 32'(i * 4)));
         tick();
      end
      check_val("tail_rec", out_rec, mk_rec(16'd10, 32'h200));
      tick();
      check_val("ovf_drained", out_valid, 0);

      // ---- drop and clr_drop in the same cycle (seq 11..18 fill, 19 drop) ----
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 1'b1, 32'h500, 1'b0, 1'b1);
      tick();
      check_val("clrwin_drop", drop_cnt, 0);
      check_val("clrwin_ovf", overflow, 0);
      set_in(1'b1, 1'b1, 32'h504, 1'b0, 1'b0);
      tick();
      check_val("drop1_cnt", drop_cnt, 1);
      check_val("drop1_ovf", overflow, 1);
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      check_val("clr_cnt", drop_cnt, 0);
      check_val("clr_ovf", overflow, 0);
      check_val("clr_head", out_rec, mk_rec(16'd11, 32'h400));

      // ---- trace_en falling keeps entries; pop 3 to reach count 5 ----
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check_val("five_count", count, 5);
      check_val("five_head", out_rec, mk_rec(16'd14, 32'h40c));

      // ---- asynchronous reset mid-operation ----
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_valid", out_valid, 0);
      check_val("async_count", count, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_in(1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check_val("post_rst_rec", out_rec, mk_rec(16'd0, 32'h300));

      // ---- seq wrap under continuous draining ----
      do_reset();
      pop_idx     = 0;
      stream_errs = 0;
      w0          = 16'hffff;
      w1          = 16'hffff;
      for (int i = 0; i < 65538; i++) begin
         set_in(1'b1, 1'b1, 32'(i * 4), 1'b1, 1'b0);
         if (out_valid) begin
            if (out_rec !== mk_rec(16'(pop_idx), 32'(pop_idx * 4))) stream_errs++;
            if (pop_idx == 65536) w0 = out_rec.seq;
            if (pop_idx == 65537) w1 = out_rec.seq;
            pop_idx++;
         end
         tick();
      end
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int k = 0; k < DEPTH + 2; k++) begin
         if (out_valid) begin
            if (out_rec !== mk_rec(16'(pop_idx), 32'(pop_idx * 4))) stream_errs++;
            if (pop_idx == 65536) w0 = out_rec.seq;
            if (pop_idx == 65537) w1 = out_rec.seq;
            pop_idx++;
         end
         tick();
      end
      check_val("wrap_pops", pop_idx, 65538);
      check_val("wrap_stream", stream_errs, 0);
      check_val("wrap_seq0", w0, 16'h0000);
      check_val("wrap_seq1", w1, 16'h0001);
      check_val("wrap_drop", drop_cnt, 0);
      check_val("wrap_ovf", overflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
